// File: rtl/inv_sub_bytes_seq_if.sv
// rtl/inv_sub_bytes_seq_if.sv - block handshake and shared S-box lane signals for inv_sub_bytes_seq
interface inv_sub_bytes_seq_if #(
   parameter int NBYTES = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   in_state;
   logic [7:0]            sb_byte_out;
   logic                  sb_issue;
   logic [7:0]            sb_byte_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   out_state;
   logic                  busy;

   modport master (
      output in_valid, in_state, sb_byte_in, out_ready,
      input  in_ready, sb_byte_out, sb_issue, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, sb_byte_in, out_ready,
      output in_ready, sb_byte_out, sb_issue, out_valid, out_state, busy
   );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - byte-serial scheduler feeding one shared inverse S-box lane
module inv_sub_bytes_seq #(
   parameter int NBYTES   = 16,
   parameter int SBOX_LAT = 1
) (
   input logic                clk,
   input logic                rst_n,
   inv_sub_bytes_seq_if.slave bus
);
   localparam int IW = $clog2(NBYTES);
   localparam int DW = $clog2(SBOX_LAT + 2);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
   localparam logic [DW-1:0] DRAIN_END = DW'(SBOX_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [7:0]      in_b  [NBYTES];
   logic [7:0]      res_b [NBYTES];
   logic [IW-1:0]   issue_idx;
   logic [DW-1:0]   drain_cnt;
   logic            pipe_vld [SBOX_LAT];
   logic [IW-1:0]   pipe_idx [SBOX_LAT];
   logic            rdy_en;
   logic            accept;
   logic            in_ready_c;
   logic            sb_issue_c;
   logic            out_valid_c;

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      sb_issue_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = rdy_en;
            if (bus.in_valid && rdy_en) state_nxt = ISSUE;
         end
         ISSUE: begin
            sb_issue_c = 1'b1;
            if (issue_idx == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_END) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = bus.in_valid && in_ready_c;

   // rdy_en holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy_en    <= 1'b0;
         issue_idx <= '0;
         drain_cnt <= '0;
         for (int i = 0; i < NBYTES; i++) in_b[i] <= 8'h00;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
         if (accept) begin
            for (int i = 0; i < NBYTES; i++) in_b[i] <= bus.in_state[8*(NBYTES-i)-1 -: 8];
            issue_idx <= '0;
         end else if (state == ISSUE && issue_idx != LAST_IDX) begin
            issue_idx <= issue_idx + IW'(1);
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
         else                drain_cnt <= '0;
      end
   end

   // The live issue is stage 0 of the capture pipe; these registers are stages 1..SBOX_LAT,
   // so the tail lines up with the cycle the S-box result is on sb_byte_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < SBOX_LAT; j++) begin
            pipe_vld[j] <= 1'b0;
            pipe_idx[j] <= '0;
         end
         for (int i = 0; i < NBYTES; i++) res_b[i] <= 8'h00;
      end else begin
         pipe_vld[0] <= sb_issue_c;
         pipe_idx[0] <= issue_idx;
         for (int j = 1; j < SBOX_LAT; j++) begin
            pipe_vld[j] <= pipe_vld[j-1];
            pipe_idx[j] <= pipe_idx[j-1];
         end
         if (pipe_vld[SBOX_LAT-1]) res_b[pipe_idx[SBOX_LAT-1]] <= bus.sb_byte_in;
      end
   end

   always_comb begin
      bus.out_state = '0;
      for (int i = 0; i < NBYTES; i++) bus.out_state[8*(NBYTES-i)-1 -: 8] = res_b[i];
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.sb_issue    = sb_issue_c;
   assign bus.sb_byte_out = sb_issue_c ? in_b[issue_idx] : 8'h00;
   assign bus.out_valid   = out_valid_c;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - directed bench for inv_sub_bytes_seq with a registered inverse S-box model
module tb_inv_sub_bytes_seq;
   logic clk;
   logic rst_n;
   int   checks;
   int   passes;
   int   cyc;
   logic [7:0] inv_sbox [256];

   inv_sub_bytes_seq_if #(.NBYTES(16)) bus ();

   inv_sub_bytes_seq #(.NBYTES(16), .SBOX_LAT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) bus.sb_byte_in <= inv_sbox[bus.sb_byte_out];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      if (a == 8'h00) r = 8'h00;
      else for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*(16-i)-1 -: 8] = inv_sbox[d[8*(16-i)-1 -: 8]];
      return r;
   endfunction

   task automatic send_block(input logic [127:0] d, output bit ok);
      ok = 1'b0;
      bus.in_state = d;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (ok) begin @(posedge clk); #1; end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n, output bit ok);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (bus.out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic take_out;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] d, output logic [127:0] res, output bit ok);
      bit ok1, ok2;
      int n;
      send_block(d, ok1);
      wait_out(n, ok2);
      res = bus.out_state;
      ok = ok1 && ok2;
      if (ok2) take_out();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_state = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.sb_issue, bus.sb_byte_out, bus.out_valid, bus.busy} !== 12'h000)
         $display("FAIL reset_ctrl: got %h want 000", {bus.in_ready, bus.sb_issue, bus.sb_byte_out, bus.out_valid, bus.busy});
      else passes++;
      checks++;
      if (bus.out_state !== 128'h0) $display("FAIL reset_out_state: got %h want 0", bus.out_state);
      else passes++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
         $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", bus.in_ready, bus.busy);
      else passes++;
   endtask

   task automatic test_t1_latency;
      bit ok1, ok2;
      int n;
      send_block(128'h000102030405060708090a0b0c0d0e0f, ok1);
      checks++;
      if (!ok1 || bus.sb_issue !== 1'b1 || bus.sb_byte_out !== 8'h00 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL t1_first_issue: ok=%b issue=%b byte=%h in_ready=%b busy=%b want 1 1 00 0 1",
                  ok1, bus.sb_issue, bus.sb_byte_out, bus.in_ready, bus.busy);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (bus.sb_byte_out !== 8'h01) $display("FAIL t1_second_issue: got %h want 01", bus.sb_byte_out);
      else passes++;
      wait_out(n, ok2);
      n++;
      checks++;
      if (!ok2 || n !== 17) $display("FAIL t1_latency: got %0d cycles want 17", n);
      else passes++;
      checks++;
      if (bus.out_state !== 128'h52096ad53036a538bf40a39e81f3d7fb)
         $display("FAIL t1_out_state: got %h want 52096ad53036a538bf40a39e81f3d7fb", bus.out_state);
      else passes++;
      take_out();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL t1_out_drop: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
      else passes++;
   endtask

   task automatic test_t2_patterns;
      logic [127:0] r;
      bit ok;
      run_block({16{8'h63}}, r, ok);
      checks++;
      if (!ok || r !== 128'h0) $display("FAIL t2_all63: got %h want 0", r);
      else passes++;
      run_block({16{8'hff}}, r, ok);
      checks++;
      if (!ok || r !== {16{8'h7d}}) $display("FAIL t2_allff: got %h want %h", r, {16{8'h7d}});
      else passes++;
   endtask

   task automatic test_t3_backpressure;
      logic [127:0] d = 128'hdeadbeef0123456789abcdeffedcba98;
      logic [127:0] held;
      bit ok1, ok2;
      int n;
      send_block(d, ok1);
      wait_out(n, ok2);
      held = bus.out_state;
      checks++;
      if (!ok1 || !ok2 || held !== model(d)) $display("FAIL t3_result: got %h want %h", held, model(d));
      else passes++;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_state !== held || bus.in_ready !== 1'b0 || bus.sb_issue !== 1'b0)
            $display("FAIL t3_hold_%0d: out_valid=%b in_ready=%b sb_issue=%b state=%h want 1 0 0 %h",
                     k, bus.out_valid, bus.in_ready, bus.sb_issue, bus.out_state, held);
         else passes++;
      end
      take_out();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL t3_taken: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      else passes++;
   endtask

   task automatic test_back_to_back;
      logic [127:0] a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      logic [127:0] b = 128'h11223344556677889900aabbccddeeff;
      logic [127:0] outs [$];
      int acc [$];
      bus.in_state = a;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 80 && !(acc.size() == 2 && outs.size() == 2); i++) begin
         if (bus.in_valid && bus.in_ready) acc.push_back(cyc + 1);
         if (bus.out_valid && bus.out_ready) outs.push_back(bus.out_state);
         @(posedge clk); #1;
         if (acc.size() == 1) bus.in_state = b;
         if (acc.size() == 2) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (acc.size() != 2 || acc[1] - acc[0] != 19)
         $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2 19", acc.size(), acc.size() == 2 ? acc[1] - acc[0] : -1);
      else passes++;
      checks++;
      if (outs.size() != 2 || outs[0] !== model(a) || outs[1] !== model(b))
         $display("FAIL b2b_results: count=%0d first=%h want %h", outs.size(), outs.size() > 0 ? outs[0] : 128'h0, model(a));
      else passes++;
   endtask

   task automatic test_mid_reset;
      logic [127:0] d = 128'h102132435465768798a9bacbdcedfe0f;
      logic [127:0] r;
      bit ok;
      bit seen = 1'b0;
      send_block(d, ok);
      repeat (7) begin @(posedge clk); #1; end
      checks++;
      if (!ok || bus.sb_issue !== 1'b1 || bus.sb_byte_out !== 8'h87)
         $display("FAIL t5_byte7: issue=%b byte=%h want 1 87", bus.sb_issue, bus.sb_byte_out);
      else passes++;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.sb_issue, bus.sb_byte_out, bus.out_valid, bus.busy} !== 12'h000 || bus.out_state !== 128'h0)
         $display("FAIL t5_async_reset: ctrl=%h out_state=%h want 000 0",
                  {bus.in_ready, bus.sb_issue, bus.sb_byte_out, bus.out_valid, bus.busy}, bus.out_state);
      else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL t5_ready_after: got %b want 1", bus.in_ready);
      else passes++;
      for (int i = 0; i < 25; i++) begin
         if (bus.out_valid || bus.busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL t5_no_stale_out: got activity=%b want 0", seen);
      else passes++;
      run_block(128'hffeeddccbbaa99887766554433221100, r, ok);
      checks++;
      if (!ok || r !== model(128'hffeeddccbbaa99887766554433221100))
         $display("FAIL t5_next_block: got %h want %h", r, model(128'hffeeddccbbaa99887766554433221100));
      else passes++;
   endtask

   task automatic test_input_hold;
      logic [127:0] d = 128'h5a5aa5a5c3c33c3c0123456789abcdef;
      bit ok1;
      bit ok2 = 1'b0;
      send_block(d, ok1);
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) begin ok2 = 1'b1; break; end
         bus.in_state = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      checks++;
      if (!ok1 || !ok2 || bus.out_state !== model(d))
         $display("FAIL t6_latched: got %h want %h", bus.out_state, model(d));
      else passes++;
      if (ok2) take_out();
   endtask

   initial begin
      checks = 0;
      passes = 0;
      cyc = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_state = '0;
      bus.out_ready = 1'b0;
      bus.sb_byte_in = 8'h00;
      for (int i = 0; i < 256; i++) inv_sbox[fwd_sbox(8'(i))] = 8'(i);
      test_reset();
      test_t1_latency();
      test_t2_patterns();
      test_t3_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_input_hold();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
